// File: rtl/reglk_ctrl_gen_if.sv
// Register-bus bundle for the lock controller: request/grant plus one-cycle
// response. The master drives requests and the slave returns responses.
interface reglk_ctrl_gen_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic                  err_o;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, err_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, err_o, rdata_o
  );
endinterface

// File: rtl/reglk_ctrl_gen.sv
// Peripheral lock-word register file. Commits are two-step (arm, then confirm
// within a timeout). A debug unlock wipes all lock state.
//
//   state  | meaning
//   OPEN   | lock words and RDPROT writable
//   ARMED  | first LOCK write seen; waiting for the confirming LOCK write
//   LOCKED | lock words frozen until jtag unlock or reset
module reglk_ctrl_gen #(
  parameter int NB_PERIPHERALS = 14,
  parameter int LK_WIDTH       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int ARM_TIMEOUT    = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               jtag_unlock_i,
  input  logic                               acct_ctrl_i,
  reglk_ctrl_gen_if.slave                    bus,
  output logic [NB_PERIPHERALS*LK_WIDTH-1:0] reglk_ctrl_o,
  output logic                               locked_o
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int CW = $clog2(ARM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [NB_PERIPHERALS*LK_WIDTH-1:0] words_q;
  logic                               rdprot_q;

  logic [IW-1:0]         idx;
  logic [31:0]           idx_w;
  logic                  acc, ok, is_lk, is_ctrl, is_stat, lock_wr;
  logic                  lk_we, rdprot_we, resp_err;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [LK_WIDTH-1:0]   rd_word;
  logic                  unused_bits;

  assign bus.gnt_o = bus.req_i & ~jtag_unlock_i;
  assign acc       = bus.req_i & bus.gnt_o;
  assign ok        = acc & acct_ctrl_i;
  assign idx       = bus.addr_i[ADDR_WIDTH-1:2];
  assign idx_w     = 32'(idx);
  assign is_lk     = idx_w < 32'(NB_PERIPHERALS);
  assign is_ctrl   = idx_w == 32'(NB_PERIPHERALS);
  assign is_stat   = idx_w == 32'(NB_PERIPHERALS + 1);
  assign lock_wr   = ok & bus.we_i & is_ctrl & bus.wdata_i[0];

  assign reglk_ctrl_o = words_q;
  assign locked_o     = (state_q == ST_LOCKED);
  assign unused_bits  = ^{bus.addr_i[1:0], bus.wdata_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_OPEN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A confirming write wins over expiry in the last ARMED cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OPEN: begin
        if (lock_wr) begin
          state_d = ST_ARMED;
          cnt_d   = CW'(ARM_TIMEOUT - 1);
        end
      end
      ST_ARMED: begin
        if (lock_wr) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_OPEN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_LOCKED: ;
      default: state_d = ST_OPEN;
    endcase
    if (jtag_unlock_i) begin
      state_d = ST_OPEN;
      cnt_d   = '0;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB_PERIPHERALS; i++) begin
      if (idx_w == 32'(i)) rd_word = words_q[i*LK_WIDTH +: LK_WIDTH];
    end
  end

  always_comb begin
    resp_err  = 1'b0;
    resp_data = '0;
    lk_we     = 1'b0;
    rdprot_we = 1'b0;
    if (acc) begin
      if (!acct_ctrl_i || !(is_lk || is_ctrl || is_stat)) begin
        resp_err = 1'b1;
      end else if (is_lk) begin
        if (bus.we_i && state_q != ST_OPEN) begin
          resp_err = 1'b1;
        end else begin
          resp_data = rdprot_q ? '0 : DATA_WIDTH'(rd_word);
          lk_we     = bus.we_i;
        end
      end else if (is_ctrl) begin
        if (bus.we_i && state_q == ST_LOCKED) begin
          resp_err = 1'b1;
        end else begin
          resp_data = DATA_WIDTH'({rdprot_q, state_q == ST_LOCKED});
          rdprot_we = bus.we_i && (state_q == ST_OPEN);
        end
      end else if (bus.we_i) begin
        resp_err = 1'b1;
      end else begin
        resp_data = DATA_WIDTH'(state_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q      <= '0;
      rdprot_q     <= 1'b0;
      bus.rvalid_o <= 1'b0;
      bus.err_o    <= 1'b0;
      bus.rdata_o  <= '0;
    end else begin
      bus.rvalid_o <= acc;
      bus.err_o    <= resp_err;
      bus.rdata_o  <= resp_data;
      if (jtag_unlock_i) begin
        words_q  <= '0;
        rdprot_q <= 1'b0;
      end else begin
        for (int i = 0; i < NB_PERIPHERALS; i++) begin
          if (lk_we && idx_w == 32'(i)) words_q[i*LK_WIDTH +: LK_WIDTH] <= bus.wdata_i[LK_WIDTH-1:0];
        end
        if (rdprot_we) rdprot_q <= bus.wdata_i[1];
      end
    end
  end
endmodule

// File: tb/tb_reglk_ctrl_gen.sv
// Directed scenarios followed by random bus traffic, checked against a
// time-based model of the lock register file.
module tb_reglk_ctrl_gen;
  localparam int NB = 14;
  localparam int LK = 8;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int AT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jtag = 1'b0;
  logic acct = 1'b1;
  logic [NB*LK-1:0] reglk;
  logic locked;

  reglk_ctrl_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reglk_ctrl_gen #(
    .NB_PERIPHERALS(NB), .LK_WIDTH(LK), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .ARM_TIMEOUT(AT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .jtag_unlock_i(jtag), .acct_ctrl_i(acct),
    .bus(bus), .reglk_ctrl_o(reglk), .locked_o(locked)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Model: state 0 OPEN, 1 ARMED, 2 LOCKED; ARMED remembered as the edge it began.
  logic [7:0] m_words[NB];
  logic       m_rdprot;
  int         m_state;
  int         m_arm;
  logic [DW-1:0] rd;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB*LK-1:0] m_vec();
    logic [NB*LK-1:0] v;
    for (int i = 0; i < NB; i++) v[i*LK +: LK] = m_words[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NB; i++) m_words[i] = 8'h00;
    m_rdprot = 1'b0;
    m_state  = 0;
    m_arm    = 0;
  endtask

  // ARMED lasts ARM_TIMEOUT cycles: a request at edge arm+AT still sees ARMED.
  task automatic m_expire(input int e);
    if (m_state == 1 && (e - m_arm) > AT) m_state = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rvalid_idle", 128'(bus.rvalid_o), 128'(1'b0));
    end
  endtask

  task automatic xfer(input logic w, input int idx, input logic [DW-1:0] d, input logic a,
                      output logic [DW-1:0] got);
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    int            e;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = AW'(idx * 4); bus.wdata_i = d; acct = a;
    #1 chk("gnt", 128'(bus.gnt_o), 128'(1'b1));
    @(posedge clk); #1;
    e = edges;
    bus.req_i = 1'b0; acct = 1'b1;
    m_expire(e);
    exp_err = 1'b0;
    exp_rd  = '0;
    if (!a || idx > NB + 1) begin
      exp_err = 1'b1;
    end else if (idx < NB) begin
      if (w && m_state != 0) exp_err = 1'b1;
      else begin
        exp_rd = m_rdprot ? 32'h0 : 32'(m_words[idx]);
        if (w) m_words[idx] = d[7:0];
      end
    end else if (idx == NB) begin
      if (w && m_state == 2) exp_err = 1'b1;
      else begin
        exp_rd = {30'b0, m_rdprot, m_state == 2};
        if (w && m_state == 0) begin
          m_rdprot = d[1];
          if (d[0]) begin m_state = 1; m_arm = e; end
        end else if (w && m_state == 1 && d[0]) begin
          m_state = 2;
        end
      end
    end else begin
      if (w) exp_err = 1'b1;
      else exp_rd = 32'(m_state);
    end
    chk("rvalid", 128'(bus.rvalid_o), 128'(1'b1));
    chk("err", 128'(bus.err_o), 128'(exp_err));
    chk("rdata", 128'(bus.rdata_o), 128'(exp_rd));
    chk("reglk", 128'(reglk), 128'(m_vec()));
    chk("locked", 128'(locked), 128'(m_state == 2));
    got = bus.rdata_o;
  endtask

  task automatic jtag_pulse(input logic with_req);
    @(negedge clk);
    jtag = 1'b1;
    if (with_req) begin
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = '0; bus.wdata_i = '1;
    end
    #1 chk("gnt_jtag", 128'(bus.gnt_o), 128'(1'b0));
    @(posedge clk); #1;
    jtag = 1'b0; bus.req_i = 1'b0;
    m_clear();
    chk("rvalid_jtag", 128'(bus.rvalid_o), 128'(1'b0));
    chk("reglk_jtag", 128'(reglk), 128'(m_vec()));
    chk("locked_jtag", 128'(locked), 128'(1'b0));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = AW'((NB + 1) * 4);
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", 128'(bus.rvalid_o), 128'(1'b0));
    chk("rst_err", 128'(bus.err_o), 128'(1'b0));
    chk("rst_rdata", 128'(bus.rdata_o), 128'(0));
    chk("rst_reglk", 128'(reglk), 128'(0));
    chk("rst_locked", 128'(locked), 128'(1'b0));
    @(posedge clk); #1;
    chk("rst_rvalid_hold", 128'(bus.rvalid_o), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1; bus.req_i = 1'b0;
    m_clear();
    @(posedge clk); #1;
    chk("rst_no_stray", 128'(bus.rvalid_o), 128'(1'b0));
  endtask

  initial begin
    int r, idx;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    m_clear();
    #1;
    chk("por_rvalid", 128'(bus.rvalid_o), 128'(1'b0));
    chk("por_reglk", 128'(reglk), 128'(0));
    chk("por_locked", 128'(locked), 128'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // write then read back word 3
    xfer(1'b1, 3, 32'h5A, 1'b1, rd);
    chk("word3_out", 128'(reglk[31:24]), 128'(8'h5A));
    xfer(1'b0, 3, 32'h0, 1'b1, rd);
    chk("word3_rd", 128'(rd), 128'(32'h5A));

    // arm, let it time out, then a lock-word write succeeds
    xfer(1'b1, NB, 32'h1, 1'b1, rd);
    idle(AT);
    xfer(1'b0, NB + 1, 32'h0, 1'b1, rd);
    chk("status_timeout", 128'(rd), 128'(0));
    xfer(1'b1, 0, 32'hFF, 1'b1, rd);

    // arm and confirm 3 cycles apart, then lock-word write rejected
    xfer(1'b1, NB, 32'h1, 1'b1, rd);
    idle(2);
    xfer(1'b1, NB, 32'h1, 1'b1, rd);
    chk("locked_after_commit", 128'(locked), 128'(1'b1));
    xfer(1'b1, 0, 32'h12, 1'b1, rd);
    xfer(1'b1, NB, 32'h0, 1'b1, rd);
    xfer(1'b1, NB + 1, 32'h0, 1'b1, rd);

    // debug unlock beats a same-cycle write
    jtag_pulse(1'b1);

    // access denied, then read protection
    xfer(1'b1, 1, 32'h77, 1'b1, rd);
    xfer(1'b1, 1, 32'h33, 1'b0, rd);
    xfer(1'b1, NB, 32'h2, 1'b1, rd);
    xfer(1'b0, 1, 32'h0, 1'b1, rd);
    chk("rdprot_read", 128'(rd), 128'(0));
    xfer(1'b1, NB, 32'h0, 1'b1, rd);
    xfer(1'b0, NB + 3, 32'h0, 1'b1, rd);

    // arm, then reset mid-ARMED
    xfer(1'b1, NB, 32'h1, 1'b1, rd);
    idle(3);
    reset_pulse();
    xfer(1'b0, NB + 1, 32'h0, 1'b1, rd);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) idle(AT + $urandom_range(0, 4));
      else idle($urandom_range(0, 3));
      r = $urandom_range(0, 39);
      if (r == 0) jtag_pulse(1'($urandom_range(0, 1)));
      else begin
        idx = (r < 12) ? NB : $urandom_range(0, NB + 3);
        xfer(1'($urandom_range(0, 1)), idx, $urandom, 1'($urandom_range(0, 7) != 0), rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reglk_ctrl_gen.md
REGLK_CTRL_GEN -- requirements
Module: reglk_ctrl_gen

Interface
REQ-001 SHALL have parameter NB_PERIPHERALS, default 14, number of peripheral lock words (1..62).
REQ-002 SHALL have parameter LK_WIDTH, default 8, lock bits per peripheral (1..DATA_WIDTH).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, byte address width; word index = addr_i[ADDR_WIDTH-1:2].
REQ-005 SHALL have parameter ARM_TIMEOUT, default 16, cycles the ARMED state waits for commit (>=2).
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port jtag_unlock_i, input, 1, debug unlock, sampled synchronously.
REQ-009 SHALL have port acct_ctrl_i, input, 1, access permission for bus requests.
REQ-010 SHALL have ports req_i (1), we_i (1), addr_i (ADDR_WIDTH), wdata_i (DATA_WIDTH), all inputs: bus request.
REQ-011 SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-012 SHALL have ports rvalid_o (1), err_o (1), rdata_o (DATA_WIDTH), all outputs: response.
REQ-013 SHALL have port reglk_ctrl_o, output, NB_PERIPHERALS*LK_WIDTH, concatenated lock words; peripheral i at [i*LK_WIDTH +: LK_WIDTH].
REQ-014 SHALL have port locked_o, output, 1, high in LOCKED state.

Function
REQ-015 SHALL implement this register map: index 0..NB_PERIPHERALS-1 = lock words (LK_WIDTH LSBs, upper bits read 0); index NB = CTRL (bit0 LOCK, bit1 RDPROT); index NB+1 = STATUS, read-only (bits[1:0] = state code OPEN=0, ARMED=1, LOCKED=2).
REQ-016 SHALL drive gnt_o = req_i, except gnt_o = 0 in any cycle where jtag_unlock_i = 1.
REQ-017 SHALL complete an accepted request (req_i & gnt_o at edge N) with rvalid_o = 1 for exactly one cycle after edge N, with rdata_o and err_o valid in that cycle; responses are not back-pressured.
REQ-018 SHALL, when acct_ctrl_i = 0 at acceptance: respond err_o = 1, rdata_o = 0, and change no state.
REQ-019 SHALL, for index > NB+1: respond err_o = 1, rdata_o = 0.
REQ-020 SHALL implement FSM OPEN -> ARMED on write to CTRL with bit0 = 1; on entry, load the timeout counter with ARM_TIMEOUT-1.
REQ-021 SHALL implement ARMED -> LOCKED on a second CTRL write with bit0 = 1 before the counter reaches 0.
REQ-022 SHALL implement ARMED -> OPEN when the counter reaches 0 with no commit; the counter decrements once per cycle in ARMED.
REQ-023 SHALL, in ARMED, ignore a CTRL write with bit0 = 0 without error, leaving the state and counter unchanged.
REQ-024 SHALL make lock-word writes take effect in OPEN only; in ARMED or LOCKED they are dropped with err_o = 1.
REQ-025 SHALL make a STATUS write, or any CTRL write in LOCKED, a no-op with err_o = 1.
REQ-026 SHALL latch RDPROT from CTRL writes in OPEN; while RDPROT = 1, lock-word reads return 0 with err_o = 0.
REQ-027 SHALL, when jtag_unlock_i = 1 at an edge: clear all lock words and RDPROT, force OPEN, and clear the counter. This has priority over any same-cycle bus write.
REQ-028 SHALL drive reglk_ctrl_o and locked_o directly from registers, with no combinational path from the bus.
REQ-029 SHALL ensure a write response reports the value before the write; a write becomes visible on reglk_ctrl_o one cycle after acceptance.

Reset
REQ-030 SHALL, while rst_ni = 0, asynchronously force: lock words 0, RDPROT 0, state OPEN, counter 0, rvalid_o 0, err_o 0, rdata_o 0, locked_o 0.
REQ-031 SHALL abort any in-flight request on reset; no response is issued for it after release.

Verification
REQ-032 SHALL pass this scenario: write index 3 = 0x5A in OPEN, then read index 3 -> reglk_ctrl_o[31:24] = 0x5A one cycle after acceptance; read rdata_o = 0x5A, err_o = 0.
REQ-033 SHALL pass this scenario: write CTRL = 1 twice, 3 cycles apart -> locked_o = 1; a subsequent write to index 0 gives err_o = 1 and reglk_ctrl_o is unchanged.
REQ-034 SHALL pass this scenario: write CTRL = 1, then idle 16 cycles -> STATUS reads 0 (OPEN); a lock-word write then succeeds.
REQ-035 SHALL pass this scenario: in LOCKED with word 0 = 0xFF, pulse jtag_unlock_i together with a req_i write -> gnt_o = 0, all words 0, locked_o = 0 the next cycle.
REQ-036 SHALL pass this scenario: acct_ctrl_i = 0 with a write to index 1 -> err_o = 1 and word 1 unchanged; with RDPROT = 1, reading index 1 returns 0 with err_o = 0.
REQ-037 SHALL pass this scenario: rst_ni asserted mid-ARMED for 1 cycle -> STATUS = 0, all outputs 0, and no stray rvalid_o.
